// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply/divide op encodings, FSM states and
// the iteration count of the sequential multiply/divide unit.
package mips_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int unsigned ITERACOES = 32;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        CALCULO = 2'b01,
        AJUSTE  = 2'b10
    } estado_t;

endpackage

// File: rtl/passo_divisao.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it is non-negative.
module passo_divisao #(
    parameter int unsigned LARGURA = 32
) (
    input  logic [LARGURA:0]   resto_parcial,
    input  logic [LARGURA-1:0] divisor,
    output logic [LARGURA-1:0] resto_novo,
    output logic               bit_quociente
);

    logic [LARGURA:0] diferenca;

    always_comb begin
        diferenca     = resto_parcial - {1'b0, divisor};
        bit_quociente = ~diferenca[LARGURA];
        // When the subtraction underflows the old remainder is below the
        // divisor, so its top bit is zero and the low bits hold it entirely.
        resto_novo    = bit_quociente ? diferenca[LARGURA-1:0] : resto_parcial[LARGURA-1:0];
    end

endmodule

// File: rtl/unidade_multdiv.sv
// Sequential MIPS multiply/divide unit: 32-step shift-add multiply and
// restoring divide on magnitudes, with sign correction before the result.
module unidade_multdiv
    import mips_pkg::*;
#(
    parameter int unsigned LARGURA = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [LARGURA-1:0]     operando_a,
    input  logic [LARGURA-1:0]     operando_b,
    output logic                   busy,
    output logic                   done,
    output logic [2*LARGURA-1:0]   dados_escrita_64
);

    localparam int unsigned CW = $clog2(ITERACOES);
    localparam logic [CW-1:0] ULTIMA = CW'(ITERACOES - 1);

    estado_t                estado_q;
    logic [CW-1:0]          cont_q;
    logic                   op_div_q;
    logic                   div_zero_q;
    logic                   sinal_a_q;
    logic                   sinal_b_q;
    logic [LARGURA-1:0]     a_bruto_q;
    logic [LARGURA-1:0]     fator_q;
    logic [2*LARGURA-1:0]   p_q;

    logic                   op_sinalizada;
    logic                   op_divisao;
    logic                   neg_a;
    logic                   neg_b;
    logic [LARGURA-1:0]     abs_a;
    logic [LARGURA-1:0]     abs_b;
    logic [LARGURA:0]       mult_soma;
    logic [2*LARGURA-1:0]   mult_prox;
    logic [LARGURA:0]       resto_parcial;
    logic [LARGURA-1:0]     resto_novo;
    logic                   bit_quociente;
    logic [2*LARGURA-1:0]   div_prox;
    logic [2*LARGURA-1:0]   produto_final;
    logic [LARGURA-1:0]     quociente_final;
    logic [LARGURA-1:0]     resto_final;

    always_comb begin
        op_sinalizada = (op == OP_MULT) || (op == OP_DIV);
        op_divisao    = (op == OP_DIV) || (op == OP_DIVU);
        neg_a         = op_sinalizada & operando_a[LARGURA-1];
        neg_b         = op_sinalizada & operando_b[LARGURA-1];
        abs_a         = neg_a ? -operando_a : operando_a;
        abs_b         = neg_b ? -operando_b : operando_b;
    end

    // p_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        mult_soma     = {1'b0, p_q[2*LARGURA-1:LARGURA]}
                      + {1'b0, (p_q[0] ? fator_q : {LARGURA{1'b0}})};
        mult_prox     = {mult_soma, p_q[LARGURA-1:1]};
        resto_parcial = {p_q[2*LARGURA-1:LARGURA], p_q[LARGURA-1]};
        div_prox      = {resto_novo, p_q[LARGURA-2:0], bit_quociente};
    end

    passo_divisao #(
        .LARGURA (LARGURA)
    ) u_passo_divisao (
        .resto_parcial (resto_parcial),
        .divisor       (fator_q),
        .resto_novo    (resto_novo),
        .bit_quociente (bit_quociente)
    );

    always_comb begin
        produto_final   = (sinal_a_q ^ sinal_b_q) ? -p_q : p_q;
        quociente_final = (sinal_a_q ^ sinal_b_q) ? -p_q[LARGURA-1:0] : p_q[LARGURA-1:0];
        resto_final     = sinal_a_q ? -p_q[2*LARGURA-1:LARGURA] : p_q[2*LARGURA-1:LARGURA];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q         <= OCIOSO;
            cont_q           <= '0;
            op_div_q         <= 1'b0;
            div_zero_q       <= 1'b0;
            sinal_a_q        <= 1'b0;
            sinal_b_q        <= 1'b0;
            a_bruto_q        <= '0;
            fator_q          <= '0;
            p_q              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            dados_escrita_64 <= '0;
        end else begin
            done <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (start) begin
                        op_div_q   <= op_divisao;
                        div_zero_q <= op_divisao && (operando_b == '0);
                        sinal_a_q  <= neg_a;
                        sinal_b_q  <= neg_b;
                        a_bruto_q  <= operando_a;
                        cont_q     <= '0;
                        busy       <= 1'b1;
                        if (op_divisao) begin
                            fator_q <= abs_b;
                            p_q     <= {{LARGURA{1'b0}}, abs_a};
                        end else begin
                            fator_q <= abs_a;
                            p_q     <= {{LARGURA{1'b0}}, abs_b};
                        end
                        // Division by zero has a fixed result, so skip the iterations.
                        if (op_divisao && (operando_b == '0)) begin
                            estado_q <= AJUSTE;
                        end else begin
                            estado_q <= CALCULO;
                        end
                    end
                end
                CALCULO: begin
                    p_q    <= op_div_q ? div_prox : mult_prox;
                    cont_q <= cont_q + 1'b1;
                    if (cont_q == ULTIMA) begin
                        estado_q <= AJUSTE;
                    end
                end
                AJUSTE: begin
                    if (div_zero_q) begin
                        dados_escrita_64 <= {a_bruto_q, {LARGURA{1'b1}}};
                    end else if (op_div_q) begin
                        dados_escrita_64 <= {resto_final, quociente_final};
                    end else begin
                        dados_escrita_64 <= produto_final;
                    end
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    estado_q <= OCIOSO;
                end
                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_multdiv.sv
// Directed self-checking bench for unidade_multdiv: latency, signed/unsigned
// results, divide-by-zero, ignored starts, reset abort and back-to-back ops.
module tb_unidade_multdiv;
    import mips_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operando_a;
    logic [31:0] operando_b;
    logic        busy;
    logic        done;
    logic [63:0] dados_escrita_64;

    int erros;
    int total;

    unidade_multdiv #(
        .LARGURA (32)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .op               (op),
        .operando_a       (operando_a),
        .operando_b       (operando_b),
        .busy             (busy),
        .done             (done),
        .dados_escrita_64 (dados_escrita_64)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one start pulse; returns just after edge E0.
    task automatic iniciar(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op         = o;
        operando_a = a;
        operando_b = b;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Edges from E0 until done is seen high; 0 if the bound expires.
    task automatic esperar_done(input int limite, output int arestas);
        arestas = 0;
        for (int n = 1; n <= limite; n++) begin
            tick();
            if (done === 1'b1) begin
                arestas = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        total++;
        if (busy !== 1'b0) begin erros++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++;
        if (done !== 1'b0) begin erros++; $display("FAIL reset_done got=%b want=0", done); end
        total++;
        if (dados_escrita_64 !== 64'd0) begin
            erros++; $display("FAIL reset_dados got=%h want=0", dados_escrita_64);
        end
        // reset wins over a simultaneous start
        op = OP_MULTU; operando_a = 32'd3; operando_b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin erros++; $display("FAIL reset_prio_busy got=%b want=0", busy); end
    endtask

    task automatic test_mult();
        int lat;
        iniciar(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        total++;
        if (busy !== 1'b1) begin erros++; $display("FAIL mult_busy got=%b want=1", busy); end
        esperar_done(40, lat);
        total++;
        if (lat != 33) begin erros++; $display("FAIL mult_latencia got=%0d want=33", lat); end
        total++;
        if (dados_escrita_64 !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            erros++; $display("FAIL mult_resultado got=%h want=ffffffffffffffeb", dados_escrita_64);
        end
        total++;
        if (busy !== 1'b0) begin erros++; $display("FAIL mult_busy_fim got=%b want=0", busy); end
        tick();
        total++;
        if (done !== 1'b0) begin erros++; $display("FAIL mult_done_pulso got=%b want=0", done); end
        total++;
        if (dados_escrita_64 !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            erros++; $display("FAIL mult_retencao got=%h want=ffffffffffffffeb", dados_escrita_64);
        end
    endtask

    task automatic test_multu();
        int lat;
        iniciar(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        esperar_done(40, lat);
        total++;
        if (dados_escrita_64 !== 64'hFFFF_FFFE_0000_0001) begin
            erros++; $display("FAIL multu_resultado got=%h want=fffffffe00000001", dados_escrita_64);
        end
    endtask

    task automatic test_div();
        int lat;
        iniciar(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        esperar_done(40, lat);
        total++;
        if (lat != 33) begin erros++; $display("FAIL div_latencia got=%0d want=33", lat); end
        total++;
        if (dados_escrita_64 !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            erros++; $display("FAIL div_resultado got=%h want=fffffffffffffffd", dados_escrita_64);
        end
        iniciar(OP_DIVU, 32'd100, 32'd7);
        esperar_done(40, lat);
        total++;
        if (dados_escrita_64 !== {32'd2, 32'd14}) begin
            erros++; $display("FAIL divu_resultado got=%h want=000000020000000e", dados_escrita_64);
        end
    endtask

    task automatic test_div_limites();
        int lat;
        iniciar(OP_DIVU, 32'd5, 32'd0);
        esperar_done(40, lat);
        total++;
        if (lat != 1) begin erros++; $display("FAIL divzero_latencia got=%0d want=1", lat); end
        total++;
        if (dados_escrita_64 !== {32'd5, 32'hFFFF_FFFF}) begin
            erros++; $display("FAIL divzero_resultado got=%h want=00000005ffffffff", dados_escrita_64);
        end
        total++;
        if (busy !== 1'b0) begin erros++; $display("FAIL divzero_busy got=%b want=0", busy); end
        iniciar(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        esperar_done(40, lat);
        total++;
        if (dados_escrita_64 !== {32'd0, 32'h8000_0000}) begin
            erros++; $display("FAIL div_minimo got=%h want=0000000080000000", dados_escrita_64);
        end
    endtask

    task automatic test_ignora_start_e_reset();
        int primeiro;
        int pulsos;
        primeiro = 0;
        pulsos   = 0;
        iniciar(OP_MULTU, 32'd3, 32'd4);
        for (int e = 1; e <= 40; e++) begin
            if (e == 5) begin
                op = OP_MULTU; operando_a = 32'd9; operando_b = 32'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done === 1'b1) begin
                pulsos++;
                if (primeiro == 0) primeiro = e;
            end
        end
        total++;
        if (primeiro != 33) begin erros++; $display("FAIL ignora_latencia got=%0d want=33", primeiro); end
        total++;
        if (pulsos != 1) begin erros++; $display("FAIL ignora_pulsos got=%0d want=1", pulsos); end
        total++;
        if (dados_escrita_64 !== 64'd12) begin
            erros++; $display("FAIL ignora_resultado got=%h want=000000000000000c", dados_escrita_64);
        end
        // third operation aborted by reset at E10
        iniciar(OP_MULT, 32'd2, 32'd3);
        for (int e = 1; e <= 9; e++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0) begin erros++; $display("FAIL aborto_busy got=%b want=0", busy); end
        total++;
        if (dados_escrita_64 !== 64'd0) begin
            erros++; $display("FAIL aborto_dados got=%h want=0", dados_escrita_64);
        end
        pulsos = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (done === 1'b1) pulsos++;
        end
        total++;
        if (pulsos != 0) begin erros++; $display("FAIL aborto_done got=%0d want=0", pulsos); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int alterado;
        iniciar(OP_DIVU, 32'd100, 32'd7);
        esperar_done(40, lat);
        // start during the done cycle becomes the next E0
        op = OP_MULTU; operando_a = 32'd3; operando_b = 32'd4; start = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 0;
        alterado = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (done === 1'b1) begin
                lat = e;
                break;
            end
            if (dados_escrita_64 !== {32'd2, 32'd14}) alterado++;
        end
        total++;
        if (lat != 33) begin erros++; $display("FAIL b2b_latencia got=%0d want=33", lat); end
        total++;
        if (alterado != 0) begin erros++; $display("FAIL b2b_retencao got=%0d want=0", alterado); end
        total++;
        if (dados_escrita_64 !== 64'd12) begin
            erros++; $display("FAIL b2b_resultado got=%h want=000000000000000c", dados_escrita_64);
        end
    endtask

    initial begin
        erros      = 0;
        total      = 0;
        reset      = 1'b1;
        start      = 1'b0;
        op         = OP_MULT;
        operando_a = '0;
        operando_b = '0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_limites();
        test_ignora_start_e_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", erros, total);
        $finish;
    end

endmodule
